// File: rtl/fifo_pkg.sv
// Shared types for the configurable synchronous FIFO: read mode and occupancy state.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  typedef enum logic [1:0] {
    stEmpty   = 2'd0,
    stPartial = 2'd1,
    stFull    = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/fifo_sync_cfg_if.sv
// Handshake, control and status bundle between a FIFO user (master) and the FIFO (slave).
interface fifo_sync_cfg_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             flush_i;
  logic             clr_err_i;
  logic             wen_i;
  logic [WIDTH-1:0] wdata_i;
  logic             full_o;
  logic             almost_full_o;
  logic             overflow_o;
  logic             ren_i;
  logic [WIDTH-1:0] rdata_o;
  logic             rvalid_o;
  logic             empty_o;
  logic             almost_empty_o;
  logic             underflow_o;
  logic [LW-1:0]    level_o;

  modport master (
    output flush_i, clr_err_i, wen_i, wdata_i, ren_i,
    input  full_o, almost_full_o, overflow_o, rdata_o, rvalid_o,
           empty_o, almost_empty_o, underflow_o, level_o
  );

  modport slave (
    input  flush_i, clr_err_i, wen_i, wdata_i, ren_i,
    output full_o, almost_full_o, overflow_o, rdata_o, rvalid_o,
           empty_o, almost_empty_o, underflow_o, level_o
  );

endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write, one registered and one combinational read port.
module fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata_q,
  output logic [WIDTH-1:0] rdata_c
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)  rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/fifo_sync_cfg.sv
// Configurable single-clock FIFO with level thresholds, sticky error flags and STD/FWFT read modes.
module fifo_sync_cfg
  import fifo_pkg::*;
#(
  parameter int         WIDTH        = 32,
  parameter int         DEPTH        = 16,
  parameter int         ALMOST_FULL  = DEPTH - 1,
  parameter int         ALMOST_EMPTY = 1,
  parameter fifo_mode_e MODE         = FIFO_STD
) (
  input  logic           clk_i,
  input  logic           arst_i,
  fifo_sync_cfg_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] AF_LVL  = LW'(ALMOST_FULL);
  localparam logic [LW-1:0] AE_LVL  = LW'(ALMOST_EMPTY);
  localparam logic [LW-1:0] DEP_LVL = LW'(DEPTH);

  fifo_state_e      state_q, state_d;
  logic [LW-1:0]    wptr_q, rptr_q, level_q, level_d;
  logic             full, empty;
  logic             wr_acc, rd_acc, ovf_set, udf_set;
  logic             ovf_q, udf_q, af_q, ae_q, rvalid_q;
  logic [WIDTH-1:0] rdata_q, rdata_c;

  // Flush overrides both requests; a write while full only goes in if a read frees a slot.
  assign rd_acc  = !bus.flush_i && bus.ren_i && !empty;
  assign wr_acc  = !bus.flush_i && bus.wen_i && (!full || rd_acc);
  assign ovf_set = !bus.flush_i && bus.wen_i && !wr_acc;
  assign udf_set = !bus.flush_i && bus.ren_i && !rd_acc;

  always_comb begin
    level_d = level_q;
    if (bus.flush_i)          level_d = '0;
    else if (wr_acc && !rd_acc) level_d = level_q + LW'(1);
    else if (rd_acc && !wr_acc) level_d = level_q - LW'(1);
  end

  // State register
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= stEmpty;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.flush_i) begin
      state_d = stEmpty;
    end else begin
      unique case (state_q)
        stEmpty:   if (wr_acc) state_d = stPartial;
        stPartial: begin
          if (level_d == DEP_LVL)  state_d = stFull;
          else if (level_d == '0)  state_d = stEmpty;
        end
        stFull:    if (rd_acc && !wr_acc) state_d = stPartial;
        default:   state_d = stEmpty;
      endcase
    end
  end

  // Output decode of the registered state
  always_comb begin
    full  = 1'b0;
    empty = 1'b0;
    unique case (state_q)
      stEmpty: empty = 1'b1;
      stFull:  full  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      af_q     <= (ALMOST_FULL == 0);
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      if (bus.flush_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (wr_acc) wptr_q <= wptr_q + LW'(1);
        if (rd_acc) rptr_q <= rptr_q + LW'(1);
      end
      level_q  <= level_d;
      af_q     <= (level_d >= AF_LVL);
      ae_q     <= (level_d <= AE_LVL);
      // A new error wins over a coincident clear.
      ovf_q    <= (ovf_q && !bus.clr_err_i) || ovf_set;
      udf_q    <= (udf_q && !bus.clr_err_i) || udf_set;
      rvalid_q <= rd_acc;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .we      (wr_acc),
    .waddr   (wptr_q[AW-1:0]),
    .wdata   (bus.wdata_i),
    .re      (rd_acc),
    .raddr   (rptr_q[AW-1:0]),
    .rdata_q (rdata_q),
    .rdata_c (rdata_c)
  );

  // FWFT shows the head word whenever something is stored; zero otherwise so reset reads 0.
  always_comb begin
    if (MODE == FIFO_FWFT) begin
      bus.rvalid_o = !empty;
      bus.rdata_o  = empty ? '0 : rdata_c;
    end else begin
      bus.rvalid_o = rvalid_q;
      bus.rdata_o  = rdata_q;
    end
  end

  assign bus.full_o         = full;
  assign bus.empty_o        = empty;
  assign bus.almost_full_o  = af_q;
  assign bus.almost_empty_o = ae_q;
  assign bus.overflow_o     = ovf_q;
  assign bus.underflow_o    = udf_q;
  assign bus.level_o        = level_q;

endmodule

// File: tb/tb_fifo_sync_cfg.sv
// Directed scoreboard bench for fifo_sync_cfg at DEPTH=4, WIDTH=8 in STD and FWFT modes.
module tb_fifo_sync_cfg;
  import fifo_pkg::*;

  logic clk  = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  fifo_sync_cfg_if #(.WIDTH(8), .DEPTH(4)) bs ();
  fifo_sync_cfg_if #(.WIDTH(8), .DEPTH(4)) bf ();

  fifo_sync_cfg #(.WIDTH(8), .DEPTH(4), .MODE(FIFO_STD)) u_std (
    .clk_i (clk), .arst_i (arst), .bus (bs)
  );

  fifo_sync_cfg #(.WIDTH(8), .DEPTH(4), .MODE(FIFO_FWFT)) u_fwft (
    .clk_i (clk), .arst_i (arst), .bus (bf)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] expq [$];
  logic [7:0] exp_head;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bs.flush_i = 0; bs.clr_err_i = 0; bs.wen_i = 0; bs.ren_i = 0; bs.wdata_i = '0;
    bf.flush_i = 0; bf.clr_err_i = 0; bf.wen_i = 0; bf.ren_i = 0; bf.wdata_i = '0;
  endtask

  // Scoreboard monitor: every STD read-data pulse must match the next queued word.
  always @(negedge clk) begin
    if (!arst && bs.rvalid_o) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %0h expected none", bs.rdata_o);
      end else begin
        exp_head = expq.pop_front();
        if (bs.rdata_o !== exp_head) begin
          errors++;
          $display("FAIL sb_data: got %0h expected %0h", bs.rdata_o, exp_head);
        end
      end
    end
  end

  initial begin
    idle();
    #12;
    chk("rst_empty",  bs.empty_o,        1);
    chk("rst_full",   bs.full_o,         0);
    chk("rst_level",  bs.level_o,        0);
    chk("rst_af",     bs.almost_full_o,  0);
    chk("rst_ae",     bs.almost_empty_o, 1);
    chk("rst_ovf",    bs.overflow_o,     0);
    chk("rst_udf",    bs.underflow_o,    0);
    chk("rst_rvalid", bs.rvalid_o,       0);
    chk("rst_rdata",  bs.rdata_o,        0);
    chk("rst_f_rvalid", bf.rvalid_o,     0);
    chk("rst_f_rdata",  bf.rdata_o,      0);
    @(negedge clk);
    arst = 1'b0;
    tick();

    // Fill 0x11..0x44
    for (int i = 0; i < 4; i++) begin
      bs.wen_i   = 1;
      bs.wdata_i = 8'((i + 1) * 17);
      expq.push_back(8'((i + 1) * 17));
      tick();
      if (i == 2) begin
        chk("fill_l3_level", bs.level_o,       3);
        chk("fill_l3_af",    bs.almost_full_o, 1);
        chk("fill_l3_full",  bs.full_o,        0);
      end
    end
    bs.wen_i = 0;
    chk("fill_full",  bs.full_o,  1);
    chk("fill_level", bs.level_o, 4);

    // Overflow: 0x55 is dropped
    bs.wen_i = 1; bs.wdata_i = 8'h55;
    tick();
    bs.wen_i = 0;
    chk("ovf_flag",  bs.overflow_o, 1);
    chk("ovf_level", bs.level_o,    4);

    // Write+read while full: head 0x11 leaves, 0xAA enters at the tail
    bs.wen_i = 1; bs.ren_i = 1; bs.wdata_i = 8'hAA;
    expq.push_back(8'hAA);
    tick();
    bs.wen_i = 0; bs.ren_i = 0;
    chk("fullsim_level", bs.level_o, 4);
    chk("fullsim_full",  bs.full_o,  1);

    bs.clr_err_i = 1;
    tick();
    bs.clr_err_i = 0;
    chk("ovf_clr", bs.overflow_o, 0);

    // Drain 0x22, 0x33, 0x44, 0xAA
    bs.ren_i = 1;
    repeat (4) tick();
    bs.ren_i = 0;
    chk("drain_empty", bs.empty_o,        1);
    chk("drain_level", bs.level_o,        0);
    chk("drain_ae",    bs.almost_empty_o, 1);
    chk("drain_udf",   bs.underflow_o,    0);
    tick();

    // Wrap: pointers cycle past 2*DEPTH
    for (int i = 0; i < 10; i++) begin
      bs.wen_i = 1; bs.wdata_i = 8'(i);
      expq.push_back(8'(i));
      tick();
      bs.wen_i = 0;
      chk("wrap_level1", bs.level_o, 1);
      bs.ren_i = 1;
      tick();
      bs.ren_i = 0;
      chk("wrap_level0", bs.level_o, 0);
    end
    tick();
    chk("wrap_ovf", bs.overflow_o,  0);
    chk("wrap_udf", bs.underflow_o, 0);

    // Empty read and clear interplay
    bs.ren_i = 1;
    tick();
    bs.ren_i = 0;
    chk("udf_set", bs.underflow_o, 1);
    chk("udf_rvalid", bs.rvalid_o, 0);
    bs.clr_err_i = 1;
    tick();
    bs.clr_err_i = 0;
    chk("udf_clr", bs.underflow_o, 0);
    bs.clr_err_i = 1; bs.ren_i = 1;
    tick();
    bs.clr_err_i = 0; bs.ren_i = 0;
    chk("udf_clr_vs_set", bs.underflow_o, 1);

    // Flush keeps the sticky flag
    bs.flush_i = 1;
    tick();
    bs.flush_i = 0;
    chk("flush_keeps_udf", bs.underflow_o, 1);
    bs.clr_err_i = 1;
    tick();
    bs.clr_err_i = 0;

    // Write+read while empty: write lands, read rejected
    bs.wen_i = 1; bs.ren_i = 1; bs.wdata_i = 8'h77;
    expq.push_back(8'h77);
    tick();
    bs.wen_i = 0; bs.ren_i = 0;
    chk("emptysim_level", bs.level_o,     1);
    chk("emptysim_udf",   bs.underflow_o, 1);
    chk("emptysim_empty", bs.empty_o,     0);
    bs.ren_i = 1;
    tick();
    bs.ren_i = 0;
    tick();

    // FWFT: head visible without a read request
    bf.wen_i = 1; bf.wdata_i = 8'h5A;
    tick();
    bf.wen_i = 0;
    chk("fwft_rdata",  bf.rdata_o,  8'h5A);
    chk("fwft_rvalid", bf.rvalid_o, 1);
    chk("fwft_empty",  bf.empty_o,  0);
    bf.wen_i = 1; bf.wdata_i = 8'h6B;
    tick();
    bf.wdata_i = 8'h7C;
    tick();
    bf.wen_i = 0;
    chk("fwft_level3", bf.level_o, 3);
    chk("fwft_hold",   bf.rdata_o, 8'h5A);
    bf.ren_i = 1;
    tick();
    bf.ren_i = 0;
    chk("fwft_adv",    bf.rdata_o, 8'h6B);
    chk("fwft_level2", bf.level_o, 2);
    bf.flush_i = 1; bf.wen_i = 1; bf.wdata_i = 8'h99;
    tick();
    bf.flush_i = 0; bf.wen_i = 0;
    chk("fwft_flush_empty",  bf.empty_o,  1);
    chk("fwft_flush_level",  bf.level_o,  0);
    chk("fwft_flush_rvalid", bf.rvalid_o, 0);
    bf.wen_i = 1; bf.wdata_i = 8'h42;
    tick();
    bf.wen_i = 0;
    chk("fwft_after_flush", bf.rdata_o, 8'h42);
    chk("fwft_after_level", bf.level_o, 1);

    repeat (2) tick();
    chk("sb_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_sync_cfg.md
FIFO_SYNC_CFG -- requirements
Module: fifo_sync_cfg

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width in bits, >=1.
REQ-002 SHALL have parameter DEPTH, default 16: number of entries, a power of two >=2.
REQ-003 SHALL have parameter ALMOST_FULL, default DEPTH-1: almost-full level threshold.
REQ-004 SHALL have parameter ALMOST_EMPTY, default 1: almost-empty level threshold.
REQ-005 SHALL have parameter MODE, default FIFO_STD: read mode, either FIFO_STD (registered read) or FIFO_FWFT (first-word-fall-through).
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port arst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port flush_i, input, 1 bit: synchronous clear of contents.
REQ-009 SHALL have port clr_err_i, input, 1 bit: clears the sticky error flags.
REQ-010 SHALL have port wdata_i, input, WIDTH bits: write data.
REQ-011 SHALL have port wen_i, input, 1 bit: write request.
REQ-012 SHALL have port full_o, output, 1 bit: FIFO full.
REQ-013 SHALL have port almost_full_o, output, 1 bit: level_o >= ALMOST_FULL.
REQ-014 SHALL have port overflow_o, output, 1 bit: sticky write-while-full flag.
REQ-015 SHALL have port ren_i, input, 1 bit: read request.
REQ-016 SHALL have port rdata_o, output, WIDTH bits: read data.
REQ-017 SHALL have port rvalid_o, output, 1 bit: rdata_o holds valid data.
REQ-018 SHALL have port empty_o, output, 1 bit: FIFO empty.
REQ-019 SHALL have port almost_empty_o, output, 1 bit: level_o <= ALMOST_EMPTY.
REQ-020 SHALL have port underflow_o, output, 1 bit: sticky read-while-empty flag.
REQ-021 SHALL have port level_o, output, $clog2(DEPTH)+1 bits: current entry count, 0..DEPTH.

Function
REQ-022 SHALL implement a state machine with states stEmpty, stPartial and stFull, as follows.
- stEmpty -> stPartial on an accepted write.
- stPartial -> stFull when level reaches DEPTH.
- stPartial -> stEmpty when level reaches 0.
- stFull -> stPartial on an accepted read without a write.
REQ-023 SHALL drive full_o = (state==stFull) and empty_o = (state==stEmpty), both from registers.
REQ-024 SHALL accept a write when wen_i && (!full_o || read accepted in the same cycle); the word goes into mem[wptr] and wptr advances.
REQ-025 SHALL accept a read when ren_i && !empty_o; rptr advances.
REQ-026 SHALL, on a simultaneous write and read while empty, accept the write, reject the read and set underflow_o.
REQ-027 SHALL, on a simultaneous accepted write and read, leave level_o unchanged.
REQ-028 SHALL use pointers of $clog2(DEPTH)+1 bits, wrapping naturally modulo 2*DEPTH; the index is the low bits.
REQ-029 SHALL, on a rejected write, leave memory untouched and set overflow_o on the next edge.
REQ-030 SHALL, on a rejected read, leave rptr unchanged and set underflow_o on the next edge.
REQ-031 SHALL hold overflow_o and underflow_o until clr_err_i or reset; if clr_err_i coincides with a new error, the flag stays set.
REQ-032 SHALL, in FIFO_STD mode, present rdata_o one cycle after an accepted read with rvalid_o pulsed high for that cycle; rdata_o holds its value otherwise.
REQ-033 SHALL, in FIFO_FWFT mode, present the head word on rdata_o with rvalid_o = !empty_o, and advance to the next word on the edge of an accepted read.
REQ-034 SHALL update level_o, almost_full_o and almost_empty_o on the same edge as the pointer change.
REQ-035 SHALL, on flush_i, zero the pointers and level, enter stEmpty and deassert rvalid_o on the next edge.
REQ-036 SHALL give flush_i priority over wen_i and ren_i in the same cycle, and SHALL NOT clear the sticky flags on flush.

Reset
REQ-037 SHALL, while arst_i is high, immediately force the following:
- wptr = rptr = 0, level_o = 0, state stEmpty, empty_o = 1.
- full_o = 0, almost_full_o = (ALMOST_FULL==0), almost_empty_o = 1.
- overflow_o = 0, underflow_o = 0, rvalid_o = 0, rdata_o = 0.
REQ-038 SHALL leave memory contents unreset, and SHALL abandon any data pending mid-operation at reset.

Structure
REQ-039 SHALL take typedef fifo_mode_e {FIFO_STD, FIFO_FWFT} and the state enum from the shared package fifo_pkg.
REQ-040 SHALL place storage in sub-module fifo_mem: a WIDTH x DEPTH array with a synchronous write and both registered and combinational read ports.

Verification
REQ-041 SHALL cover the following directed scenarios at DEPTH=4, WIDTH=8.
- Fill: write 0x11..0x44 -> full_o=1 and level_o=4 after the 4th edge; almost_full_o=1 at level 3.
- Overflow: a 5th write of 0x55 -> overflow_o=1; drain yields 0x11,0x22,0x33,0x44; 0x55 is never output.
- Wrap: 10 write/read pairs of 0x00..0x09 -> data in order, level_o stays 0/1, no error flags.
- Full simultaneous: at full, wen+ren with 0xAA -> level_o stays 4, head is 0x11, 0xAA is read last.
- Empty read: ren while empty -> underflow_o=1; clr_err_i clears it; clr_err_i plus a new underflow leaves it at 1.
- FWFT: with MODE=FIFO_FWFT, write 0x5A -> rdata_o=0x5A and rvalid_o=1 on the next cycle before ren_i; flush mid-fill -> empty_o=1 and level_o=0.
